memory_unit: RTL and testbench
==============================

MEMORY_UNIT -- requirements
Module: memory_unit

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning the word count of the unified instruction/data RAM.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning the extra stall cycles per access when MEM_WAIT_EN is defined.
REQ-003 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port IorD  input  1  address select: 0 selects pc, 1 selects alu_out.
REQ-006 SHALL have port MemRead  input  1  read request level.
REQ-007 SHALL have port MemWrite  input  1  write request level.
REQ-008 SHALL have port IRWrite  input  1  instruction-register load enable for fetches.
REQ-009 SHALL have port pc  input  32  byte address used for fetches.
REQ-010 SHALL have port alu_out  input  32  byte address used for data accesses.
REQ-011 SHALL have port write_data  input  32  store data.
REQ-012 SHALL have port instr  output  32  instruction register.
REQ-013 SHALL have port mdr  output  32  memory data register.
REQ-014 SHALL have port mem_ready  output  1  one-cycle pulse marking access completion.
REQ-015 SHALL have port addr_err  output  1  one-cycle pulse marking a rejected access.

Function
REQ-016 SHALL implement the FSM states IDLE, WAIT and DONE.
REQ-017 SHALL sample requests only in IDLE; MemRead or MemWrite requests arriving in WAIT or DONE SHALL be ignored.
REQ-018 SHALL, on acceptance, latch the address (IorD ? alu_out : pc), the direction, write_data, and the flag is_fetch = !IorD && IRWrite.
REQ-019 SHALL, for a request accepted at edge E0, move IDLE->DONE at E0+1 when WAIT_CYCLES is 0 or MEM_WAIT_EN is undefined; otherwise it SHALL pass through WAIT for exactly WAIT_CYCLES cycles before DONE.
REQ-020 SHALL hold mem_ready high for exactly the one cycle spent in DONE, and DONE SHALL always return to IDLE on the next edge.
REQ-021 SHALL, on read completion, load mdr with RAM[addr[31:2]] on the edge entering DONE, and SHALL also load instr only when is_fetch is set.
REQ-022 SHALL, on write completion, update RAM[addr[31:2]] on the edge entering DONE and leave instr and mdr unchanged.
REQ-023 SHALL, if MemRead and MemWrite are sampled high together in IDLE, perform no access, pulse addr_err, and pulse mem_ready, both via DONE with normal latency.
REQ-024 SHALL treat a misaligned address (addr[1:0]!=0) or an address with addr[31:2] >= DEPTH_WORDS as an error: no RAM, instr or mdr update; addr_err and mem_ready pulse together in DONE.
REQ-025 SHALL re-accept a request level that is still held on the IDLE cycle following DONE as a new access, so a requester holding the level gets back-to-back accesses.
REQ-026 SHALL keep instr and mdr stable between completions.

Reset
REQ-027 SHALL, while rst is high at a clock edge, force the FSM to IDLE and set instr=0, mdr=0, mem_ready=0, addr_err=0 and the wait counter to 0.
REQ-028 SHALL, on reset during WAIT or DONE, abort the access: a pending write SHALL NOT be committed and no mem_ready pulse SHALL follow.
REQ-029 SHALL NOT clear RAM contents on reset.

Configuration
REQ-030 SHALL, with MEM_WAIT_EN defined, insert WAIT_CYCLES stall cycles per access using a counter sized $clog2(WAIT_CYCLES+1).
REQ-031 SHALL, with MEM_WAIT_EN undefined, omit the WAIT state and counter entirely, giving a fixed access latency of 1.

Structure
REQ-032 SHALL take the FSM state encoding (IDLE/WAIT/DONE) and the word-index width constant from the shared package mem_pkg.
REQ-033 SHALL place the RAM array in one sub-module, mem_array, with one synchronous read/write port, word addressing and no reset.

Verification
REQ-034 SHALL verify: RAM[0]=32'h00A00093; pc=0, IorD=0, IRWrite=1, MemRead pulse -> instr=32'h00A00093 and a single mem_ready pulse, 1 cycle later (no macro) or 3 cycles later (macro, WAIT_CYCLES=2).
REQ-035 SHALL verify: MemWrite, IorD=1, alu_out=32'h10, write_data=32'hDEADBEEF, then a read of the same address -> mdr=32'hDEADBEEF and instr unchanged.
REQ-036 SHALL verify: alu_out=32'h13 read, then alu_out=32'h400 read with DEPTH_WORDS=256 -> each gives addr_err=1 with mem_ready=1, mdr unchanged.
REQ-037 SHALL verify: MemRead=MemWrite=1 in IDLE -> addr_err pulse, RAM unmodified.
REQ-038 SHALL verify: with the macro defined, a write to address 32'h20 followed by rst in WAIT -> RAM[8] keeps its old value, no mem_ready pulse, and FSM in IDLE.
REQ-039 SHALL verify: MemRead held high for 6 cycles with no macro -> mem_ready pulses on alternating cycles, 3 pulses.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: definitions shared by the unified instruction/data memory unit.
//   state_e    - FSM encoding (IDLE / WAIT / DONE)
//   WORD_IDX_W - width of the word index taken from a byte address (addr[31:2])
//   req_t      - one access request, as captured when the FSM accepts it
//   addr_ok()  - word-aligned and inside the RAM
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int WORD_IDX_W = 30;

  typedef struct packed {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic        is_fetch;
  } req_t;

  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth);
    logic [WORD_IDX_W-1:0] idx;
    idx = addr[31:2];
    return (addr[1:0] == 2'b00) && ({{(32-WORD_IDX_W){1'b0}}, idx} < depth);
  endfunction

endpackage

// File: rtl/mem_array.sv
// mem_array: word-addressed RAM with a single port.
// Writes are committed on the rising clock edge. The read data follows
// the address combinationally, so the controller can capture the word on
// the same edge that completes the access.
// Ports:
//   clk      - clock
//   we_i     - write enable for this edge
//   addr_i   - word index
//   wdata_i  - write data
//   rdata_o  - read data at addr_i
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                    clk,
  input  logic                    we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
  input  logic [31:0]             wdata_i,
  output logic [31:0]             rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // NOTE: the array has no reset on purpose; contents must survive rst, and
  // a reset would also prevent the array from mapping onto RAM macros.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/memory_unit.sv
// memory_unit: multi-cycle memory front end for a unified instruction/data
// RAM. A request is sampled only in IDLE. The access completes on the edge
// that enters DONE: reads load mdr (and instr for fetches), writes update the
// RAM, and rejected accesses only raise addr_err. DONE lasts exactly one cycle
// and mem_ready is high during it.
// Build option: MEM_WAIT_EN inserts WAIT_CYCLES stall cycles (WAIT state)
// before DONE; without it the WAIT state and counter are not built.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   IorD                      - 0: address from pc, 1: from alu_out
//   MemRead, MemWrite         - request levels
//   IRWrite                   - load instr on a fetch (IorD=0) read
//   pc, alu_out, write_data   - fetch address, data address, store data
//   instr, mdr                - instruction register, memory data register
//   mem_ready, addr_err       - completion pulse, rejected-access pulse
module memory_unit
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IorD,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        IRWrite,
  input  logic [31:0] pc,
  input  logic [31:0] alu_out,
  input  logic [31:0] write_data,
  output logic [31:0] instr,
  output logic [31:0] mdr,
  output logic        mem_ready,
  output logic        addr_err
);

  localparam int RAM_AW = $clog2(DEPTH_WORDS);

  state_e      state_q;
  req_t        req_q;
  req_t        req_in;
  req_t        cur;
  logic [31:0] instr_q, mdr_q;
  logic        mem_ready_q, addr_err_q;
  logic        req_valid;
  logic        finish;
  logic        cur_err;
  logic        ram_we;
  logic [31:0] ram_rdata;

`ifdef MEM_WAIT_EN
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  logic [CNT_W-1:0] cnt_q;
`endif

  assign req_valid       = MemRead | MemWrite;
  assign req_in.addr     = IorD ? alu_out : pc;
  assign req_in.rd       = MemRead;
  assign req_in.wr       = MemWrite;
  assign req_in.wdata    = write_data;
  assign req_in.is_fetch = !IorD && IRWrite;

  // In IDLE the access may complete on the accepting edge itself (no wait
  // states), so the live request is used; afterwards the captured copy is.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cur = req_q;
    if (state_q == IDLE) cur = req_in;
  end

  always_comb begin
    finish = 1'b0;
`ifdef MEM_WAIT_EN
    if (WAIT_CYCLES == 0) finish = (state_q == IDLE) && req_valid;
    else                  finish = (state_q == WAIT) && (cnt_q == CNT_W'(1));
`else
    finish = (state_q == IDLE) && req_valid;
`endif
  end

  // A simultaneous read+write request is rejected like a bad address.
  assign cur_err = (cur.rd & cur.wr) | !addr_ok(cur.addr, DEPTH_WORDS);
  // rst on the completing edge aborts the access, including its write.
  assign ram_we  = finish & cur.wr & !cur_err & !rst;

  mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_mem_array (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (cur.addr[RAM_AW+1:2]),
    .wdata_i (cur.wdata),
    .rdata_o (ram_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_q       <= '0;
      instr_q     <= '0;
      mdr_q       <= '0;
      mem_ready_q <= 1'b0;
      addr_err_q  <= 1'b0;
`ifdef MEM_WAIT_EN
      cnt_q       <= '0;
`endif
    end else begin
      mem_ready_q <= 1'b0;
      addr_err_q  <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            req_q <= req_in;
`ifdef MEM_WAIT_EN
            if (WAIT_CYCLES == 0) begin
              state_q <= DONE;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_W'(WAIT_CYCLES);
            end
`else
            state_q <= DONE;
`endif
          end
        end
        WAIT: begin
`ifdef MEM_WAIT_EN
          if (cnt_q == CNT_W'(1)) begin
            state_q <= DONE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
`else
          state_q <= IDLE;
`endif
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (finish) begin
        mem_ready_q <= 1'b1;
        addr_err_q  <= cur_err;
        if (!cur_err && cur.rd) begin
          mdr_q <= ram_rdata;
          if (cur.is_fetch) instr_q <= ram_rdata;
        end
      end
    end
  end

  assign instr     = instr_q;
  assign mdr       = mdr_q;
  assign mem_ready = mem_ready_q;
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_memory_unit.sv
// tb_memory_unit: table-driven check of memory_unit with a scoreboard queue.
// Each table row is one access; its expected completion is queued when the
// request is driven and compared when mem_ready is seen. Hand-written
// sequences cover held request levels and reset in the middle of an access.
module tb_memory_unit;
  import mem_pkg::*;

  localparam int DEPTH = 256;
  localparam int WCYC  = 2;
`ifdef MEM_WAIT_EN
  localparam int LAT = WCYC + 1;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        IorD = 1'b0, MemRead = 1'b0, MemWrite = 1'b0, IRWrite = 1'b0;
  logic [31:0] pc = '0, alu_out = '0, write_data = '0;
  logic [31:0] instr, mdr;
  logic        mem_ready, addr_err;

  memory_unit #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WCYC)) dut (
    .clk        (clk),
    .rst        (rst),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .pc         (pc),
    .alu_out    (alu_out),
    .write_data (write_data),
    .instr      (instr),
    .mdr        (mdr),
    .mem_ready  (mem_ready),
    .addr_err   (addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iord, rd, wr, irw;
    logic [31:0] pc, alu, wdata;
    logic        exp_err;
    logic [31:0] exp_instr, exp_mdr;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] instr, mdr;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[17];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic iord, rd, wr, irw, input logic [31:0] p, a, wd,
                              input logic e, input logic [31:0] ei, em);
    vec_t v;
    v.iord = iord; v.rd = rd; v.wr = wr; v.irw = irw;
    v.pc = p; v.alu = a; v.wdata = wd;
    v.exp_err = e; v.exp_instr = ei; v.exp_mdr = em;
    return v;
  endfunction

  // Drive one access for a single cycle, then wait (bounded) for completion.
  task automatic run_vec(input string tag, input vec_t v);
    int   cyc;
    exp_t e;
    @(negedge clk);
    IorD = v.iord; MemRead = v.rd; MemWrite = v.wr; IRWrite = v.irw;
    pc = v.pc; alu_out = v.alu; write_data = v.wdata;
    exp_q.push_back('{err: v.exp_err, instr: v.exp_instr, mdr: v.exp_mdr});
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0;
    cyc = 1;
    while (!mem_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    e = exp_q.pop_front();
    if (!mem_ready) begin
      check({tag, "_ready_timeout"}, 32'(mem_ready), 32'd1);
    end else begin
      check({tag, "_latency"}, cyc, LAT);
      check({tag, "_addr_err"}, 32'(addr_err), 32'(e.err));
      check({tag, "_instr"}, instr, e.instr);
      check({tag, "_mdr"}, mdr, e.mdr);
      @(negedge clk);
      check({tag, "_ready_single"}, 32'(mem_ready), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;

    // Data accesses use a bad pc and fetches a bad alu_out, so a wrong
    // address mux shows up as an error or wrong data.
    vecs[0]  = mk(1, 0, 1, 0, 32'hFFF, 32'h000, 32'h00A00093, 0, 32'h0,        32'h0);
    vecs[1]  = mk(0, 1, 0, 1, 32'h000, 32'hFFFFFFFF, 32'h0,   0, 32'h00A00093, 32'h00A00093);
    vecs[2]  = mk(1, 0, 1, 0, 32'hFFF, 32'h010, 32'hDEADBEEF, 0, 32'h00A00093, 32'h00A00093);
    vecs[3]  = mk(1, 1, 0, 1, 32'hFFF, 32'h010, 32'h0,        0, 32'h00A00093, 32'hDEADBEEF);
    vecs[4]  = mk(1, 1, 0, 0, 32'hFFF, 32'h013, 32'h0,        1, 32'h00A00093, 32'hDEADBEEF);
    vecs[5]  = mk(1, 1, 0, 0, 32'hFFF, 32'h400, 32'h0,        1, 32'h00A00093, 32'hDEADBEEF);
    vecs[6]  = mk(1, 1, 1, 0, 32'hFFF, 32'h010, 32'h12345678, 1, 32'h00A00093, 32'hDEADBEEF);
    vecs[7]  = mk(1, 1, 0, 0, 32'hFFF, 32'h010, 32'h0,        0, 32'h00A00093, 32'hDEADBEEF);
    vecs[8]  = mk(1, 0, 1, 0, 32'hFFF, 32'h3FC, 32'hCAFEF00D, 0, 32'h00A00093, 32'hDEADBEEF);
    vecs[9]  = mk(0, 1, 0, 1, 32'h3FC, 32'hFFFFFFFF, 32'h0,   0, 32'hCAFEF00D, 32'hCAFEF00D);
    vecs[10] = mk(0, 1, 0, 0, 32'h000, 32'hFFFFFFFF, 32'h0,   0, 32'hCAFEF00D, 32'h00A00093);
    vecs[11] = mk(1, 0, 1, 0, 32'hFFF, 32'h020, 32'h11111111, 0, 32'hCAFEF00D, 32'h00A00093);
    vecs[12] = mk(1, 0, 1, 0, 32'hFFF, 32'h022, 32'h99999999, 1, 32'hCAFEF00D, 32'h00A00093);
    vecs[13] = mk(1, 0, 1, 0, 32'hFFF, 32'h400, 32'h55555555, 1, 32'hCAFEF00D, 32'h00A00093);
    vecs[14] = mk(1, 1, 0, 0, 32'hFFF, 32'h020, 32'h0,        0, 32'hCAFEF00D, 32'h11111111);
    vecs[15] = mk(1, 1, 0, 0, 32'hFFF, 32'h000, 32'h0,        0, 32'hCAFEF00D, 32'h00A00093);
    vecs[16] = mk(0, 1, 0, 1, 32'h002, 32'hFFFFFFFF, 32'h0,   1, 32'hCAFEF00D, 32'h00A00093);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_instr", instr, 32'h0);
    check("reset_mdr", mdr, 32'h0);
    check("reset_mem_ready", 32'(mem_ready), 32'd0);
    check("reset_addr_err", 32'(addr_err), 32'd0);

    for (int i = 0; i < 17; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

`ifndef MEM_WAIT_EN
    // A held read level is re-accepted on every IDLE cycle: ready alternates.
    @(negedge clk);
    IorD = 1'b1; alu_out = 32'h010; pc = 32'hFFF; MemRead = 1'b1; IRWrite = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("hold_cycle%0d", i), 32'(mem_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      pulses += int'(mem_ready);
    end
    MemRead = 1'b0;
    check("hold_pulse_count", pulses, 3);
    check("hold_mdr", mdr, 32'hDEADBEEF);
`endif

    // Reset in the middle of a write to word 8 must drop the write.
    @(negedge clk);
    IorD = 1'b1; alu_out = 32'h020; pc = 32'hFFF; write_data = 32'h22222222;
    MemWrite = 1'b1;
`ifdef MEM_WAIT_EN
    @(negedge clk);
    MemWrite = 1'b0;
    @(negedge clk);
    check("abort_in_wait", 32'(dut.state_q), 32'(WAIT));
    rst = 1'b1;
`else
    rst = 1'b1;
`endif
    @(negedge clk);
    rst = 1'b0; MemWrite = 1'b0;
    check("abort_state_idle", 32'(dut.state_q), 32'(IDLE));
    check("abort_instr", instr, 32'h0);
    check("abort_mdr", mdr, 32'h0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      pulses += int'(mem_ready);
      @(negedge clk);
    end
    check("abort_no_ready", pulses, 0);
    run_vec("abort_readback", mk(1, 1, 0, 0, 32'hFFF, 32'h020, 32'h0, 0, 32'h0, 32'h11111111));

    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
